// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed LIF controller: buffers synaptic events into per-neuron
// accumulators, then sweeps every neuron through one shared
// leak/integrate/fire datapath per timestep and emits spikes over valid/ready.

package neuron_pkg;
    localparam int MEMBRANE_WIDTH = 16;
    localparam int WEIGHT_WIDTH   = 8;
    localparam int LEAK_WIDTH     = 8;
    typedef logic [MEMBRANE_WIDTH-1:0] membrane_t;
    localparam membrane_t THRESHOLD = 16'h1000;
    localparam membrane_t RESET_VAL = 16'h0000;
endpackage

module lif_timestep_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      step_start,
    input  logic [LEAK_WIDTH-1:0]     leak_factor,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_idx,
    input  logic [WEIGHT_WIDTH-1:0]   in_weight,
    output logic                      spike_valid,
    input  logic                      spike_ready,
    output logic [IDX_W-1:0]          spike_idx,
    output logic                      step_busy,
    output logic                      step_done,
    input  logic [IDX_W-1:0]          dbg_idx,
    output logic [MEMBRANE_WIDTH-1:0] dbg_membrane
);

    localparam int PW = MEMBRANE_WIDTH + LEAK_WIDTH;
    localparam int SW = MEMBRANE_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, EMIT, DONE} state_t;

    state_t                 state_q, state_d;
    membrane_t              membrane [NUM_NEURONS];
    membrane_t              acc      [NUM_NEURONS];
    logic [IDX_W-1:0]       cur_idx;
    logic [LEAK_WIDTH-1:0]  leak_q;

    membrane_t              v_cur, a_cur, leak_amt, v_leaked, v_int, acc_new;
    logic [PW-1:0]          leak_prod;
    logic [SW-1:0]          int_sum, acc_sum;
    logic                   fire, last_idx, ev_accept;

    // Shared leak/integrate/fire datapath, event saturation and debug read
    always_comb begin
        v_cur     = membrane[cur_idx];
        a_cur     = acc[cur_idx];
        leak_prod = PW'(v_cur) * PW'(leak_q);
        leak_amt  = leak_prod[PW-1:LEAK_WIDTH];
        v_leaked  = v_cur - leak_amt;
        int_sum   = SW'(v_leaked) + SW'(a_cur);
        v_int     = int_sum[MEMBRANE_WIDTH] ? '1 : int_sum[MEMBRANE_WIDTH-1:0];
        fire      = (v_int >= THRESHOLD);
        last_idx  = (cur_idx == IDX_W'(NUM_NEURONS - 1));
        ev_accept = in_valid && (state_q == IDLE) && (32'(in_idx) < NUM_NEURONS);
        acc_sum   = SW'(acc[in_idx]) + SW'(in_weight);
        acc_new   = acc_sum[MEMBRANE_WIDTH] ? '1 : acc_sum[MEMBRANE_WIDTH-1:0];
        dbg_membrane = (32'(dbg_idx) < NUM_NEURONS) ? membrane[dbg_idx] : '0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        step_busy = 1'b0;
        step_done = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (step_start) state_d = SWEEP;
            end
            SWEEP: begin
                step_busy = 1'b1;
                if (fire)          state_d = EMIT;
                else if (last_idx) state_d = DONE;
            end
            EMIT: begin
                step_busy = 1'b1;
                if (spike_ready) state_d = last_idx ? DONE : SWEEP;
            end
            DONE: begin
                step_busy = 1'b1;
                step_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Neuron state, sweep index, latched leak and spike output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                membrane[i] <= '0;
                acc[i]      <= '0;
            end
            cur_idx     <= '0;
            leak_q      <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_accept) acc[in_idx] <= acc_new;
                    if (step_start) begin
                        leak_q  <= leak_factor;
                        cur_idx <= '0;
                    end
                end
                SWEEP: begin
                    acc[cur_idx] <= '0;
                    if (fire) begin
                        membrane[cur_idx] <= RESET_VAL;
                        spike_valid       <= 1'b1;
                        spike_idx         <= cur_idx;
                    end else begin
                        membrane[cur_idx] <= v_int;
                        if (!last_idx) cur_idx <= cur_idx + IDX_W'(1);
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        if (!last_idx) cur_idx <= cur_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Self-checking bench for lif_timestep_scheduler (5 neurons, so indices
// 5..7 are out of range): fixed vector table, hand-written corner sequences
// and randomized steps checked against an arithmetic reference model.

module tb_lif_timestep_scheduler;

    localparam int N  = 5;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_start;
    logic [7:0]    leak_factor;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic [7:0]    in_weight;
    logic          spike_valid;
    logic          spike_ready;
    logic [IW-1:0] spike_idx;
    logic          step_busy;
    logic          step_done;
    logic [IW-1:0] dbg_idx;
    logic [15:0]   dbg_membrane;

    always #5 clk = ~clk;

    lif_timestep_scheduler #(.NUM_NEURONS(N), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .step_start(step_start), .leak_factor(leak_factor),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_weight(in_weight),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_idx(spike_idx),
        .step_busy(step_busy), .step_done(step_done),
        .dbg_idx(dbg_idx), .dbg_membrane(dbg_membrane)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_mem [N];
    int m_acc [N];
    int pre_mem [N];
    int exp_q [$];

    typedef struct {
        int idx; int weight; int count; int leak; int exp_mem; int exp_fire;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0;
            m_acc[i] = 0;
        end
    endtask

    task automatic model_event(input int idx, input int w);
        if (idx < N) begin
            m_acc[idx] = m_acc[idx] + w;
            if (m_acc[idx] > 65535) m_acc[idx] = 65535;
        end
    endtask

    task automatic model_step(input int leak);
        int v, vi;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            v  = m_mem[i];
            vi = v - (v * leak) / 256 + m_acc[i];
            if (vi > 65535) vi = 65535;
            m_acc[i] = 0;
            if (vi >= 4096) begin
                m_mem[i] = 0;
                exp_q.push_back(i);
            end else begin
                m_mem[i] = vi;
            end
        end
    endtask

    task automatic send_event(input int idx, input int w);
        in_valid  = 1'b1;
        in_idx    = IW'(idx);
        in_weight = 8'(w);
        model_event(idx, w);
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic check_all_membranes(input string tag);
        for (int i = 0; i < N; i++) begin
            dbg_idx = IW'(i);
            #1;
            check($sformatf("%s_mem%0d", tag, i), dbg_membrane, m_mem[i]);
        end
    endtask

    // One timestep; each spike is stalled for `stall` cycles before ready.
    task automatic run_step(input int leak, input int stall, input int co_idx,
                            input int co_w, output int n_spikes);
        int k, got, stall_cnt, done_k;
        bit done;
        if (co_idx >= 0) model_event(co_idx, co_w);
        for (int i = 0; i < N; i++) pre_mem[i] = m_mem[i];
        model_step(leak);

        step_start  = 1'b1;
        leak_factor = 8'(leak);
        spike_ready = (stall == 0);
        if (co_idx >= 0) begin
            in_valid  = 1'b1;
            in_idx    = IW'(co_idx);
            in_weight = 8'(co_w);
        end
        tick();
        step_start  = 1'b0;
        in_valid    = 1'b0;
        leak_factor = 8'(leak) ^ 8'h5A;
        check("busy_rise", step_busy, 1);
        check("in_ready_busy", in_ready, 0);

        got = 0; stall_cnt = 0; done = 1'b0; done_k = 0; k = 1;
        while (!done && k < 300) begin
            if (step_done) begin
                done   = 1'b1;
                done_k = k;
            end else begin
                step_start = 1'b0;
                if (spike_valid) begin
                    if (got < exp_q.size()) check("spike_idx", spike_idx, exp_q[got]);
                    else check("spike_extra", got + 1, exp_q.size());
                    if (stall_cnt < stall) begin
                        spike_ready = 1'b0;
                        step_start  = 1'b1;
                        stall_cnt++;
                        check("in_ready_stall", in_ready, 0);
                        check("valid_held", spike_valid, 1);
                        if (got < exp_q.size() && exp_q[got] + 1 < N) begin
                            dbg_idx = IW'(exp_q[got] + 1);
                            #1;
                            check("no_write_stall", dbg_membrane, pre_mem[exp_q[got] + 1]);
                        end
                    end else begin
                        spike_ready = 1'b1;
                        got++;
                        stall_cnt = 0;
                    end
                end else begin
                    spike_ready = (stall == 0);
                end
                tick();
                k++;
            end
        end
        step_start = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL step_done_timeout: got none expected pulse within 300 cycles");
        end else begin
            check("done_latency", done_k, N + 1 + exp_q.size() * (stall + 1));
        end
        check("spike_count", got, exp_q.size());
        n_spikes = got;
        tick();
        check("done_pulse_end", step_done, 0);
        check("idle_busy", step_busy, 0);
        check("idle_in_ready", in_ready, 1);
        check_all_membranes("step");
        spike_ready = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{2, 'h80,  3, 0,    'h0180, 0};
        tbl[1] = '{1, 'h80, 32, 0,    'h0000, 1};
        tbl[2] = '{0, 'h80, 16, 0,    'h0800, 0};
        tbl[3] = '{0, 0,     0, 'h80, 'h0400, 0};
        tbl[4] = '{0, 0,     0, 'hFF, 'h0004, 0};
        tbl[5] = '{3, 'hFF, 17, 0,    'h0000, 1};
        tbl[6] = '{3, 'hFF, 16, 0,    'h0FF0, 0};
        tbl[7] = '{3, 'h10,  1, 0,    'h0000, 1};
        tbl[8] = '{3, 'hFF, 16, 0,    'h0FF0, 0};
        tbl[9] = '{3, 'h0F,  1, 0,    'h0FFF, 0};

        rst_n = 1'b0; step_start = 1'b0; leak_factor = '0; in_valid = 1'b0;
        in_idx = '0; in_weight = '0; spike_ready = 1'b0; dbg_idx = '0;
        model_reset();
        tick(); tick();
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_idx", spike_idx, 0);
        check("rst_busy", step_busy, 0);
        check("rst_done", step_done, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check_all_membranes("rst");

        // Fixed vector table: each row is events then one step at leak
        foreach (tbl[r]) begin
            for (int e = 0; e < tbl[r].count; e++) send_event(tbl[r].idx, tbl[r].weight);
            run_step(tbl[r].leak, 0, -1, 0, n);
            check($sformatf("tbl%0d_fire", r), n, tbl[r].exp_fire);
            dbg_idx = IW'(tbl[r].idx);
            #1;
            check($sformatf("tbl%0d_mem", r), dbg_membrane, tbl[r].exp_mem);
        end

        // Backpressure: idx 0 and 3 both fire, each held 5 cycles
        for (int e = 0; e < 17; e++) begin
            send_event(0, 'hFF);
            send_event(3, 'hFF);
        end
        run_step(0, 5, -1, 0, n);
        check("bp_spikes", n, 2);

        // Event coincident with step_start pushes idx 1 over threshold
        for (int e = 0; e < 31; e++) send_event(1, 'h80);
        run_step(0, 0, 1, 'h80, n);
        check("coincident_fire", n, 1);

        // Accumulator saturation
        for (int e = 0; e < 600; e++) send_event(2, 'hFF);
        run_step(0, 1, -1, 0, n);
        check("sat_fire", n, 1);

        // Out-of-range events leave everything unchanged
        for (int e = 5; e < 8; e++) send_event(e, 'hFF);
        run_step(0, 0, -1, 0, n);
        check("oor_fire", n, 0);

        // Randomized steps against the reference model
        for (int it = 0; it < 25; it++) begin
            int nev, co;
            nev = $urandom_range(0, 30);
            for (int e = 0; e < nev; e++) send_event($urandom_range(0, 7), $urandom_range(0, 255));
            co = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            run_step($urandom_range(0, 48), $urandom_range(0, 2), co, $urandom_range(0, 255), n);
        end

        // Reset in the middle of a sweep with a pending accumulator
        send_event(4, 'h55);
        send_event(4, 'h55);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", spike_valid, 0);
        check("mid_rst_idx", spike_idx, 0);
        check("mid_rst_busy", step_busy, 0);
        check("mid_rst_done", step_done, 0);
        tick();
        check("mid_rst_done2", step_done, 0);
        rst_n = 1'b1;
        model_reset();
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_done", step_done, 0);
        check_all_membranes("post_rst");
        run_step(0, 0, -1, 0, n);
        check("post_rst_fire", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
